icache: RTL
===========

# icache

Direct-mapped instruction cache sitting directly upstream of the pipelined datapath's fetch stage. It takes the fetch PC, returns the instruction word in the same cycle on a hit, and raises a stall on a miss. During the stall it refills a 4-word line from a slow backing instruction memory, one word per request/acknowledge beat. The stall output is ORed into the hazard unit's `stallF`/`stallD`.

## Interface
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `WORDS`, 4: words per line; power of two, at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pcF`  in  32  fetch PC; bits [1:0] ignored.
- `instrF`  out  32  instruction word for `pcF`; 32'h0 (nop) when not a hit.
- `stallC`  out  1  cache stall; high whenever `instrF` is not valid for `pcF`.
- `inval`  in  1  invalidate all lines (single-cycle pulse).
- `mem_req`  out  1  backing-memory read request.
- `mem_addr`  out  32  word-aligned read address, held stable while `mem_req` is high.
- `mem_ack`  in  1  request accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  read data.

## Operation
- Address split, with OB = log2(WORDS) and IB = log2(LINES):
  - offset = `pcF`[OB+1:2]
  - index = `pcF`[OB+IB+1:OB+2]
  - tag = `pcF`[31:OB+IB+2]
- Storage per line: valid bit, tag, and WORDS data words.
- FSM states are IDLE and REFILL.
- IDLE behaviour:
  - Hit means valid[index] is set and the stored tag equals the `pcF` tag. On a hit: `instrF` = data[index][offset] and `stallC` = 0, both combinational.
  - On a miss: `stallC` = 1, `instrF` = 0. Latch the line base (`pcF`[31:OB+2]) into `miss_line` and go to REFILL; beat counter `beat` = 0.
- REFILL behaviour:
  - `stallC` = 1 and `instrF` = 0.
  - `mem_req` = 1 and `mem_addr` = {`miss_line`, `beat`, 2'b00}.
  - When `mem_ack` is seen, write `mem_rdata` into data[miss index][`beat`] and increment `beat`.
  - On the ack for `beat` = WORDS-1: write the tag, set valid, return to IDLE, and deassert `mem_req` next cycle.
  - With no `mem_ack`, hold `mem_req`, `mem_addr` and `beat` unchanged (unbounded wait).
- `pcF` is ignored during REFILL; the latched line always completes. The next IDLE cycle re-looks up the current `pcF`, which may miss again.
- `inval` clears all valid bits at the clock edge in any state.
  - If it coincides with the final-beat write, the refilled line ends valid and all other lines end invalid.
  - If it arrives mid-refill, it does not abort the refill.
- `mem_req` is low in IDLE. Words are never fetched out of order or speculatively.

## Timing
- Reset values: state IDLE, all valid bits 0, `beat` 0, `mem_req` 0, `mem_addr` 0. With all lines invalid, `stallC` is 1 and `instrF` is 0 immediately after reset (combinational miss).
- Hit latency is 0 cycles (combinational, same as the existing single-cycle instruction memory).
- Miss with zero-wait memory (ack every cycle):
  - Cycle 0: miss detected.
  - Cycles 1..WORDS: beats.
  - Cycle WORDS+1: hit.
  - Total is WORDS+1 stall cycles (5 by default).
- Each wait cycle (`mem_ack` low) adds exactly one stall cycle.
- Reset asserted mid-refill: return to IDLE immediately, drop `mem_req`, clear all valids. The partially written line is never marked valid.
- Tag and valid arrays update only on edges. Data written on a beat becomes visible to lookup only after the line is marked valid.

## Structure
- Package `icache_pkg`: state enum (IDLE, REFILL), and functions or localparams deriving OB, IB and tag width from `LINES`/`WORDS`.
- Sub-module `icache_array`: valid/tag/data storage with a combinational read port and a single write port (word write plus line-commit strobe), plus asynchronous clear of valids on reset and synchronous clear on `inval`.
- Top `icache`: address split, hit compare, FSM, beat counter, and memory handshake.

## Test plan
- Cold miss: reset, then `pcF`=0x100 with memory returning 0xA0..0xA3 and ack every cycle. Required: `mem_addr` steps 0x100, 0x104, 0x108, 0x10C; `stallC` is high for 5 cycles; then `instrF`=0xA0 with `stallC`=0. Following `pcF`=0x104/0x108/0x10C hit with 0xA1/0xA2/0xA3 and no stall.
- Wait states: same miss, with `mem_ack` low for 2 cycles before each beat. Required: `mem_addr` is held stable throughout and `stallC` is high for 13 cycles.
- Conflict eviction: fill 0x100, then access 0x200 (same index, different tag), then 0x100 again. Required: each access misses and refetches, and data is correct after each refill.
- Invalidate: after filling 0x100, pulse `inval`. Required: the next `pcF`=0x100 misses. `inval` on the final beat of a 0x300 refill: 0x300 hits and 0x100 misses.
- Reset mid-refill: drop `reset` after beat 1 of a 0x100 miss. Required: `mem_req` falls asynchronously; after release, 0x100 misses and fully refetches beats 0..3.
- `pcF` change during refill: switch `pcF` from 0x100 to 0x400 during beat 2. Required: the 0x100 line completes, then a 0x400 miss starts.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    function automatic int calc_ob(input int words);
        return $clog2(words);
    endfunction

    function automatic int calc_ib(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is what remains of the 32-bit PC after offset, index and the byte bits.
    function automatic int calc_tw(input int lines, input int words);
        return 32 - calc_ob(words) - calc_ib(lines) - 2;
    endfunction

endpackage

// File: rtl/icache_if.sv
// Backing instruction-memory read port: request/acknowledge with same-cycle data.
interface icache_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, one word-write port and a
// line-commit strobe that writes the tag and sets the valid bit.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    localparam int OB = calc_ob(WORDS),
    localparam int IB = calc_ib(LINES),
    localparam int TW = calc_tw(LINES, WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inval,
    input  logic [IB-1:0] rd_index,
    input  logic [OB-1:0] rd_offset,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output logic [31:0]   rd_word,
    input  logic          wr_en,
    input  logic [IB-1:0] wr_index,
    input  logic [OB-1:0] wr_offset,
    input  logic [31:0]   wr_data,
    input  logic          commit,
    input  logic [TW-1:0] commit_tag
);

    logic [LINES-1:0] valid_r;
    logic [LINES-1:0] valid_next_s;
    logic [TW-1:0]    tag_r  [LINES];
    logic [31:0]      data_r [LINES][WORDS];

    // Next valid vector: invalidate clears everything, a same-cycle commit still wins for its line.
    always_comb begin
        valid_next_s           = inval ? {LINES{1'b0}} : valid_r;
        valid_next_s[wr_index] = commit | valid_next_s[wr_index];
    end

    // Valid bits register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {LINES{1'b0}};
        end else begin
            valid_r <= valid_next_s;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_index][wr_offset] <= wr_data;
        end
        if (commit) begin
            tag_r[wr_index] <= commit_tag;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_word  = data_r[rd_index][rd_offset];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: combinational hit path, stall on miss and
// in-order refill of one line from the backing memory.
module icache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        stallC,
    input  logic        inval,
    icache_if.master    mem
);

    localparam int OB = calc_ob(WORDS);
    localparam int IB = calc_ib(LINES);
    localparam int TW = calc_tw(LINES, WORDS);
    localparam int ML = 30 - OB;
    localparam logic [OB-1:0] LAST_BEAT = OB'(WORDS - 1);
    localparam logic [OB-1:0] BEAT_ONE  = OB'(1);

    state_t        state_r;
    state_t        state_next_s;
    logic [ML-1:0] miss_line_r;
    logic [OB-1:0] beat_r;

    logic [OB-1:0] offset_s;
    logic [IB-1:0] index_s;
    logic [TW-1:0] tag_s;
    logic          pc_unused_s;
    logic          rd_valid_s;
    logic [TW-1:0] rd_tag_s;
    logic [31:0]   rd_word_s;
    logic          hit_s;
    logic          wr_en_s;
    logic          commit_s;

    assign offset_s    = pcF[OB+1:2];
    assign index_s     = pcF[OB+IB+1:OB+2];
    assign tag_s       = pcF[31:OB+IB+2];
    assign pc_unused_s = ^pcF[1:0];

    icache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
        .clk        (clk),
        .reset      (reset),
        .inval      (inval),
        .rd_index   (index_s),
        .rd_offset  (offset_s),
        .rd_valid   (rd_valid_s),
        .rd_tag     (rd_tag_s),
        .rd_word    (rd_word_s),
        .wr_en      (wr_en_s),
        .wr_index   (miss_line_r[IB-1:0]),
        .wr_offset  (beat_r),
        .wr_data    (mem.mem_rdata),
        .commit     (commit_s),
        .commit_tag (miss_line_r[ML-1:IB])
    );

    // Lookup, refill write strobes and fetch-side outputs.
    always_comb begin
        hit_s    = (state_r == IDLE) && rd_valid_s && (rd_tag_s == tag_s);
        wr_en_s  = (state_r == REFILL) && mem.mem_ack;
        commit_s = wr_en_s && (beat_r == LAST_BEAT);
        instrF   = hit_s ? rd_word_s : 32'h0000_0000;
        stallC   = ~hit_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!hit_s) begin
                    state_next_s = REFILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REFILL: begin
                if (commit_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REFILL;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Miss line latch and beat counter; the counter wraps to zero after the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_line_r <= {ML{1'b0}};
            beat_r      <= {OB{1'b0}};
        end else if ((state_r == IDLE) && !hit_s) begin
            miss_line_r <= pcF[31:OB+2];
            beat_r      <= {OB{1'b0}};
        end else if (wr_en_s) begin
            beat_r      <= beat_r + BEAT_ONE;
        end
    end

    assign mem.mem_req  = (state_r == REFILL);
    assign mem.mem_addr = {miss_line_r, beat_r, 2'b00};

endmodule
